// File: rtl/jcr_decode_pkg.sv
// Shared definitions for the jacaranda-8 decode stage: default field widths,
// the prefix opcode, the decoder state type and the immediate-width helper.
package jcr_decode_pkg;

  localparam int         DEF_INSTR_W = 8;
  localparam int         DEF_OPC_W   = 4;
  localparam int         DEF_REG_A_W = 2;
  localparam logic [3:0] DEF_PFX_OPC = 4'hF;

  typedef enum logic {
    NORM = 1'b0,
    PFX  = 1'b1
  } state_e;

  function automatic int immWidth(input int instrW, input int opcW);
    return instrW - opcW;
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational split of an instruction word into opcode, register addresses
// and the low immediate field.
module decode_fields
  import jcr_decode_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int OPC_W   = DEF_OPC_W,
  parameter int REG_A_W = DEF_REG_A_W
) (
  input  logic [INSTR_W-1:0]                    instr_i,
  output logic [OPC_W-1:0]                      opcode_o,
  output logic [REG_A_W-1:0]                    rd_a_o,
  output logic [REG_A_W-1:0]                    rs_a_o,
  output logic [immWidth(INSTR_W, OPC_W)-1:0]   imm_lo_o
);

  localparam int IMM_W = immWidth(INSTR_W, OPC_W);

  assign opcode_o = instr_i[INSTR_W-1 -: OPC_W];
  assign rd_a_o   = instr_i[2*REG_A_W-1:REG_A_W];
  assign rs_a_o   = instr_i[REG_A_W-1:0];
  assign imm_lo_o = instr_i[IMM_W-1:0];

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready output, an extended-immediate
// prefix mode and a branch flush.
module decode_stage
  import jcr_decode_pkg::*;
#(
  parameter int               INSTR_W = DEF_INSTR_W,
  parameter int               OPC_W   = DEF_OPC_W,
  parameter int               REG_A_W = DEF_REG_A_W,
  parameter logic [OPC_W-1:0] PFX_OPC = OPC_W'(DEF_PFX_OPC),
  parameter bit               SEXT    = 1'b0
) (
  input  logic                                    clock,
  input  logic                                    reset_n,
  input  logic                                    flush,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [INSTR_W-1:0]                      instr,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [OPC_W-1:0]                        opcode,
  output logic [REG_A_W-1:0]                      rd_a,
  output logic [REG_A_W-1:0]                      rs_a,
  output logic [2*immWidth(INSTR_W, OPC_W)-1:0]   imm,
  output logic                                    ext
);

  localparam int IMM_W = immWidth(INSTR_W, OPC_W);

  state_e               state_q, state_d;
  logic [IMM_W-1:0]     pfx_hi_q, pfx_hi_d;
  logic                 out_valid_q, out_valid_d;
  logic [OPC_W-1:0]     opcode_q, opcode_d;
  logic [REG_A_W-1:0]   rd_a_q, rd_a_d;
  logic [REG_A_W-1:0]   rs_a_q, rs_a_d;
  logic [2*IMM_W-1:0]   imm_q, imm_d;
  logic                 ext_q, ext_d;

  logic [OPC_W-1:0]     decOpcode;
  logic [REG_A_W-1:0]   decRd;
  logic [REG_A_W-1:0]   decRs;
  logic [IMM_W-1:0]     decImmLo;
  logic [2*IMM_W-1:0]   immExt;
  logic                 accept;

  decode_fields #(
    .INSTR_W (INSTR_W),
    .OPC_W   (OPC_W),
    .REG_A_W (REG_A_W)
  ) u_fields (
    .instr_i  (instr),
    .opcode_o (decOpcode),
    .rd_a_o   (decRd),
    .rs_a_o   (decRs),
    .imm_lo_o (decImmLo)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign immExt   = SEXT ? {{IMM_W{decImmLo[IMM_W-1]}}, decImmLo}
                         : {{IMM_W{1'b0}}, decImmLo};

  // Flush outranks any accept; a prefix word never touches the output register.
  always_comb begin
    state_d     = state_q;
    pfx_hi_d    = pfx_hi_q;
    out_valid_d = out_valid_q && !out_ready;
    opcode_d    = opcode_q;
    rd_a_d      = rd_a_q;
    rs_a_d      = rs_a_q;
    imm_d       = imm_q;
    ext_d       = ext_q;
    if (flush) begin
      state_d     = NORM;
      pfx_hi_d    = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      if (decOpcode == PFX_OPC) begin
        pfx_hi_d = decImmLo;
        state_d  = PFX;
      end else begin
        opcode_d    = decOpcode;
        rd_a_d      = decRd;
        rs_a_d      = decRs;
        imm_d       = (state_q == PFX) ? {pfx_hi_q, decImmLo} : immExt;
        ext_d       = (state_q == PFX);
        out_valid_d = 1'b1;
        state_d     = NORM;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= NORM;
      pfx_hi_q    <= '0;
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      rd_a_q      <= '0;
      rs_a_q      <= '0;
      imm_q       <= '0;
      ext_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pfx_hi_q    <= pfx_hi_d;
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      rd_a_q      <= rd_a_d;
      rs_a_q      <= rs_a_d;
      imm_q       <= imm_d;
      ext_q       <= ext_d;
    end
  end

  assign out_valid = out_valid_q;
  assign opcode    = opcode_q;
  assign rd_a      = rd_a_q;
  assign rs_a      = rs_a_q;
  assign imm       = imm_q;
  assign ext       = ext_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a zero-extending and a sign-extending
// instance run in lockstep against a small reference model.
module tb_decode_stage;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       flush;
  logic       in_valid;
  logic [7:0] instr;
  logic       out_ready;

  logic       in_ready, out_valid, ext;
  logic [3:0] opcode;
  logic [1:0] rd_a, rs_a;
  logic [7:0] imm;

  logic       sInReady, sOutValid, sExt;
  logic [3:0] sOpcode;
  logic [1:0] sRd, sRs;
  logic [7:0] sImm;

  typedef struct packed {
    logic [3:0] opc;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] immZ;
    logic [7:0] immS;
    logic       ext;
  } entry_t;

  entry_t     expQ[$];
  logic       mPfx;
  logic [3:0] mHi;
  int         checkCount = 0;
  int         failCount  = 0;

  always #5 clock = ~clock;

  decode_stage #(.SEXT(1'b0)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rd_a(rd_a), .rs_a(rs_a), .imm(imm), .ext(ext)
  );

  decode_stage #(.SEXT(1'b1)) dutS (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(sInReady), .instr(instr),
    .out_valid(sOutValid), .out_ready(out_ready),
    .opcode(sOpcode), .rd_a(sRd), .rs_a(sRs), .imm(sImm), .ext(sExt)
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drives one cycle, checks outputs before the edge, then advances the model.
  task automatic applyStimulus(input logic v, input logic [7:0] w,
                               input logic r, input logic f);
    logic   expReady;
    entry_t e;
    in_valid  = v;
    instr     = w;
    out_ready = r;
    flush     = f;
    @(negedge clock);
    expReady = (expQ.size() == 0) || r;
    checkOutput("in_ready", 16'(in_ready), 16'(expReady));
    checkOutput("s_in_ready", 16'(sInReady), 16'(expReady));
    checkOutput("out_valid", 16'(out_valid), 16'(expQ.size() != 0));
    checkOutput("s_out_valid", 16'(sOutValid), 16'(expQ.size() != 0));
    if (expQ.size() != 0) begin
      e = expQ[0];
      checkOutput("opcode", 16'(opcode), 16'(e.opc));
      checkOutput("rd_a", 16'(rd_a), 16'(e.rd));
      checkOutput("rs_a", 16'(rs_a), 16'(e.rs));
      checkOutput("imm", 16'(imm), 16'(e.immZ));
      checkOutput("ext", 16'(ext), 16'(e.ext));
      checkOutput("s_imm", 16'(sImm), 16'(e.immS));
      checkOutput("s_fields", 16'({sOpcode, sRd, sRs, sExt}),
                  16'({e.opc, e.rd, e.rs, e.ext}));
      if (r) void'(expQ.pop_front());
    end
    if (f) begin
      expQ.delete();
      mPfx = 1'b0;
      mHi  = 4'h0;
    end else if (v && expReady) begin
      if (w[7:4] == 4'hF) begin
        mHi  = w[3:0];
        mPfx = 1'b1;
      end else begin
        e.opc = w[7:4];
        e.rd  = w[3:2];
        e.rs  = w[1:0];
        if (mPfx) begin
          e.immZ = {mHi, w[3:0]};
          e.immS = {mHi, w[3:0]};
          e.ext  = 1'b1;
        end else begin
          e.immZ = {4'h0, w[3:0]};
          e.immS = {{4{w[3]}}, w[3:0]};
          e.ext  = 1'b0;
        end
        expQ.push_back(e);
        mPfx = 1'b0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    expQ.delete();
    mPfx      = 1'b0;
    mHi       = 4'h0;
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    instr     = 8'h36;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #3;
    checkOutput("rst_out_valid", 16'(out_valid), 16'h0);
    checkOutput("rst_fields", 16'({opcode, rd_a, rs_a, ext}), 16'h0);
    checkOutput("rst_imm", 16'(imm), 16'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // First accept right after reset, then SEXT contrast word and idle drain
    applyStimulus(1'b1, 8'h36, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h2C, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Prefix pair, then latest-prefix-wins triple
    applyStimulus(1'b1, 8'hFA, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h15, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hF3, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hF7, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h40, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Stall for three cycles, then release with a word waiting
    applyStimulus(1'b1, 8'h9B, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b1, 8'h51, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h62, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush while in prefix state drops the concurrent word
    applyStimulus(1'b1, 8'hFA, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h12, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'h12, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset while an entry is held
    applyStimulus(1'b1, 8'h7E, 1'b0, 1'b0);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #2;
    checkOutput("async_rst_valid", 16'(out_valid), 16'h0);
    checkOutput("async_rst_imm", 16'(imm), 16'h0);
    expQ.delete();
    mPfx = 1'b0;
    mHi  = 4'h0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Randomised traffic with prefixes, stalls and occasional flushes
    for (int i = 0; i < 200; i++) begin
      logic [7:0] w;
      w = ($urandom_range(0, 3) == 0) ? {4'hF, 4'($urandom_range(0, 15))}
                                      : 8'($urandom_range(0, 255));
      applyStimulus(1'($urandom_range(0, 3) != 0), w,
                    1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 15) == 0));
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
